// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared pixel type and skew-monitor state encoding
package pixel_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SKEW  = 2'd1,
    ST_FAULT = 2'd2
  } skew_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// rtl/pixel_fifo.sv - single-clock pixel FIFO, head shown combinationally from storage
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        push,
  input  logic [23:0] push_data,
  input  logic        pop,
  output logic        full,
  output logic        empty,
  output logic [23:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  pixel_t        mem_q [DEPTH];

  logic do_push;
  logic do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rptr_q];
  // Flush wins over both sides, so a push arriving with it is dropped.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= pixel_t'(push_data);
  end

endmodule

// File: rtl/pixel_pair_aligner.sv
// rtl/pixel_pair_aligner.sv - pairs two pixel streams and flags sustained one-sided skew
module pixel_pair_aligner
  import pixel_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int SKEW_LIMIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in1_pixel_r,
  input  logic [7:0] in1_pixel_g,
  input  logic [7:0] in1_pixel_b,
  input  logic       in1_valid,
  output logic       in1_ready,
  input  logic [7:0] in2_pixel_r,
  input  logic [7:0] in2_pixel_g,
  input  logic [7:0] in2_pixel_b,
  input  logic       in2_valid,
  output logic       in2_ready,
  output logic [7:0] out1_pixel_r,
  output logic [7:0] out1_pixel_g,
  output logic [7:0] out1_pixel_b,
  output logic [7:0] out2_pixel_r,
  output logic [7:0] out2_pixel_g,
  output logic [7:0] out2_pixel_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       skew_error,
  input  logic       clear_error
);

  localparam int SW = $clog2(SKEW_LIMIT + 1);

  pixel_t in1_pix, in2_pix, head1, head2;
  logic   full1, full2, empty1, empty2;
  logic   pop_pair;
  logic   one_sided;

  skew_state_e   state_q, state_d;
  logic [SW-1:0] skew_cnt_q, skew_cnt_d;

  assign in1_pix  = '{r: in1_pixel_r, g: in1_pixel_g, b: in1_pixel_b};
  assign in2_pix  = '{r: in2_pixel_r, g: in2_pixel_g, b: in2_pixel_b};

  assign in1_ready = ~full1;
  assign in2_ready = ~full2;
  assign out_valid = ~empty1 & ~empty2;
  assign pop_pair  = out_valid & out_ready;

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear_error),
    .push      (in1_valid),
    .push_data (in1_pix),
    .pop       (pop_pair),
    .full      (full1),
    .empty     (empty1),
    .head      (head1)
  );

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo2 (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear_error),
    .push      (in2_valid),
    .push_data (in2_pix),
    .pop       (pop_pair),
    .full      (full2),
    .empty     (empty2),
    .head      (head2)
  );

  assign out1_pixel_r = head1.r;
  assign out1_pixel_g = head1.g;
  assign out1_pixel_b = head1.b;
  assign out2_pixel_r = head2.r;
  assign out2_pixel_g = head2.g;
  assign out2_pixel_b = head2.b;

  assign one_sided  = empty1 ^ empty2;
  assign skew_error = (state_q == ST_FAULT);

  // Counter saturates at the limit so FAULT is reached once and stays sticky.
  always_comb begin
    state_d    = state_q;
    skew_cnt_d = skew_cnt_q;
    if (clear_error) begin
      state_d    = ST_RUN;
      skew_cnt_d = '0;
    end else begin
      if (!one_sided) begin
        skew_cnt_d = '0;
      end else if (skew_cnt_q != SW'(SKEW_LIMIT)) begin
        skew_cnt_d = skew_cnt_q + 1'b1;
      end
      case (state_q)
        ST_RUN: begin
          if (skew_cnt_d >= SW'(SKEW_LIMIT)) state_d = ST_FAULT;
          else if (skew_cnt_d != '0)         state_d = ST_SKEW;
        end
        ST_SKEW: begin
          if (skew_cnt_d >= SW'(SKEW_LIMIT)) state_d = ST_FAULT;
          else if (!one_sided)               state_d = ST_RUN;
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      skew_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skew_cnt_q <= skew_cnt_d;
    end
  end

endmodule

// File: tb/tb_pixel_pair_aligner.sv
// tb/tb_pixel_pair_aligner.sv - randomized self-checking bench with queue-based reference model
module tb_pixel_pair_aligner;

  localparam int DEPTH = 4;
  localparam int LIM   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] in1_px = '0, in2_px = '0;
  logic        in1_valid = 1'b0, in2_valid = 1'b0;
  logic        out_ready = 1'b0, clear_error = 1'b0;
  logic        in1_ready, in2_ready, out_valid, skew_error;
  logic [7:0]  o1r, o1g, o1b, o2r, o2g, o2b;
  logic [23:0] o1, o2;

  int checks = 0;
  int errors = 0;

  logic [23:0] q1[$];
  logic [23:0] q2[$];
  int          run_len = 0;
  bit          flag = 1'b0;

  assign o1 = {o1r, o1g, o1b};
  assign o2 = {o2r, o2g, o2b};

  always #5 clk = ~clk;

  pixel_pair_aligner #(.DEPTH(DEPTH), .SKEW_LIMIT(LIM)) dut (
    .clk          (clk),
    .rst          (rst),
    .in1_pixel_r  (in1_px[23:16]),
    .in1_pixel_g  (in1_px[15:8]),
    .in1_pixel_b  (in1_px[7:0]),
    .in1_valid    (in1_valid),
    .in1_ready    (in1_ready),
    .in2_pixel_r  (in2_px[23:16]),
    .in2_pixel_g  (in2_px[15:8]),
    .in2_pixel_b  (in2_px[7:0]),
    .in2_valid    (in2_valid),
    .in2_ready    (in2_ready),
    .out1_pixel_r (o1r),
    .out1_pixel_g (o1g),
    .out1_pixel_b (o1b),
    .out2_pixel_r (o2r),
    .out2_pixel_g (o2g),
    .out2_pixel_b (o2b),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .skew_error   (skew_error),
    .clear_error  (clear_error)
  );

  // Advance one clock and apply the same edge to the reference model.
  task automatic cycle();
    bit p1, p2, pp, one;
    @(posedge clk);
    if (rst || clear_error) begin
      q1.delete();
      q2.delete();
      run_len = 0;
      flag    = 1'b0;
    end else begin
      one     = (q1.size() > 0) != (q2.size() > 0);
      run_len = one ? run_len + 1 : 0;
      if (run_len >= LIM) flag = 1'b1;
      pp = (q1.size() > 0) && (q2.size() > 0) && out_ready;
      p1 = in1_valid && (q1.size() < DEPTH);
      p2 = in2_valid && (q2.size() < DEPTH);
      if (pp) begin
        void'(q1.pop_front());
        void'(q2.pop_front());
      end
      if (p1) q1.push_back(in1_px);
      if (p2) q2.push_back(in2_px);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL reset_in1_ready got %b want 1", in1_ready); end
    checks++; if (in2_ready !== 1'b1) begin errors++; $display("FAIL reset_in2_ready got %b want 1", in2_ready); end
    checks++; if (skew_error !== 1'b0) begin errors++; $display("FAIL reset_skew_error got %b want 0", skew_error); end
    rst = 1'b0;
    cycle();
  endtask

  task automatic test_lockstep();
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in1_valid = 1'b1;
      in2_valid = 1'b1;
      in1_px = {8'(k), 16'($urandom)};
      in2_px = {8'(k), 16'($urandom)};
      cycle();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lockstep_valid k=%0d got %b want 1", k, out_valid); end
      checks++; if (o1r !== 8'(k)) begin errors++; $display("FAIL lockstep_order k=%0d got %h want %h", k, o1r, 8'(k)); end
      if (q1.size() > 0 && q2.size() > 0) begin
        checks++; if (o1 !== q1[0] || o2 !== q2[0]) begin errors++; $display("FAIL lockstep_pair k=%0d got %h/%h want %h/%h", k, o1, o2, q1[0], q2[0]); end
      end
    end
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lockstep_drain got %b want 0", out_valid); end
  endtask

  task automatic test_offset();
    logic [23:0] e1[$];
    logic [23:0] e2[$];
    int np = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && out_ready) begin
        checks++; if (np >= 3 || o1 !== e1[np] || o2 !== e2[np]) begin errors++; $display("FAIL offset_pair n=%0d got %h/%h", np, o1, o2); end
        np++;
      end
      in1_valid = (c < 3);
      in2_valid = (c >= 2) && (c < 5);
      in1_px = 24'($urandom);
      in2_px = 24'($urandom);
      if (in1_valid) e1.push_back(in1_px);
      if (in2_valid) e2.push_back(in2_px);
      cycle();
      checks++; if (skew_error !== 1'b0) begin errors++; $display("FAIL offset_skew c=%0d got %b want 0", c, skew_error); end
    end
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    checks++; if (np !== 3) begin errors++; $display("FAIL offset_count got %0d want 3", np); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      in1_valid = 1'b1;
      in2_valid = 1'b1;
      in1_px = {8'(c + 1), 16'($urandom)};
      in2_px = {8'(c + 1), 16'($urandom)};
      cycle();
      checks++; if (in1_ready !== (c < 3) || in2_ready !== (c < 3)) begin errors++; $display("FAIL bp_ready c=%0d got %b%b want %b", c, in1_ready, in2_ready, (c < 3)); end
      checks++; if (o1r !== 8'h01 || o2r !== 8'h01) begin errors++; $display("FAIL bp_hold c=%0d got %h/%h want 01", c, o1r, o2r); end
    end
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checks++; if (out_valid !== 1'b1 || o1r !== 8'(c + 1) || o2r !== 8'(c + 1)) begin errors++; $display("FAIL bp_drain c=%0d got v=%b %h/%h want %h", c, out_valid, o1r, o2r, 8'(c + 1)); end
      cycle();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_skew();
    out_ready = 1'b1;
    in1_valid = 1'b1;
    in1_px = 24'($urandom);
    cycle();
    in1_valid = 1'b0;
    for (int t = 1; t <= 18; t++) begin
      cycle();
      checks++; if (skew_error !== (t >= LIM)) begin errors++; $display("FAIL skew_flag t=%0d got %b want %b", t, skew_error, (t >= LIM)); end
    end
    clear_error = 1'b1;
    in2_valid = 1'b1;
    cycle();
    clear_error = 1'b0;
    in2_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_valid got %b want 0", out_valid); end
    checks++; if (skew_error !== 1'b0) begin errors++; $display("FAIL clear_skew got %b want 0", skew_error); end
    checks++; if (in1_ready !== 1'b1 || in2_ready !== 1'b1) begin errors++; $display("FAIL clear_ready got %b%b want 11", in1_ready, in2_ready); end
    in1_valid = 1'b1;
    in2_valid = 1'b1;
    in1_px = 24'($urandom);
    in2_px = 24'($urandom);
    cycle();
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || o1 !== in1_px || o2 !== in2_px) begin errors++; $display("FAIL clear_flushed got v=%b %h/%h want %h/%h", out_valid, o1, o2, in1_px, in2_px); end
    cycle();
  endtask

  task automatic test_wrap();
    logic [23:0] s1[20];
    logic [23:0] s2[20];
    int i1 = 0, i2 = 0, np = 0, guard = 0;
    foreach (s1[i]) begin
      s1[i] = 24'($urandom);
      s2[i] = 24'($urandom);
    end
    while (np < 20 && guard < 400) begin
      out_ready = ($urandom_range(0, 2) != 0);
      in1_valid = (i1 < 20) && ($urandom_range(0, 3) != 0);
      in2_valid = (i2 < 20) && ($urandom_range(0, 3) != 0);
      in1_px = (i1 < 20) ? s1[i1] : 24'h0;
      in2_px = (i2 < 20) ? s2[i2] : 24'h0;
      checks++; if (out_valid !== ((q1.size() > 0) && (q2.size() > 0))) begin errors++; $display("FAIL wrap_valid g=%0d got %b", guard, out_valid); end
      checks++; if (skew_error !== flag) begin errors++; $display("FAIL wrap_skew g=%0d got %b want %b", guard, skew_error, flag); end
      if (out_valid && out_ready) begin
        checks++; if (o1 !== s1[np] || o2 !== s2[np]) begin errors++; $display("FAIL wrap_pair n=%0d got %h/%h want %h/%h", np, o1, o2, s1[np], s2[np]); end
        np++;
      end
      if (in1_valid && in1_ready) i1++;
      if (in2_valid && in2_ready) i2++;
      cycle();
      guard++;
    end
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    checks++; if (np !== 20) begin errors++; $display("FAIL wrap_count got %0d want 20", np); end
    clear_error = 1'b1;
    cycle();
    clear_error = 1'b0;
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      in1_valid = 1'b1;
      in2_valid = 1'b1;
      in1_px = 24'($urandom);
      in2_px = 24'($urandom);
      cycle();
    end
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre got %b want 1", out_valid); end
    rst = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
    checks++; if (in1_ready !== 1'b1 || in2_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b%b want 11", in1_ready, in2_ready); end
    rst = 1'b0;
    in1_valid = 1'b1;
    in2_valid = 1'b1;
    in1_px = 24'($urandom);
    in2_px = 24'($urandom);
    cycle();
    in1_valid = 1'b0;
    in2_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || o1 !== in1_px || o2 !== in2_px) begin errors++; $display("FAIL midrst_first got v=%b %h/%h want %h/%h", out_valid, o1, o2, in1_px, in2_px); end
    out_ready = 1'b1;
    cycle();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_single got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_lockstep();
    test_offset();
    test_backpressure();
    test_skew();
    test_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_pair_aligner.md
PIXEL_PAIR_ALIGNER -- requirements
Module: pixel_pair_aligner

Interface
REQ-001 Parameter DEPTH, default 4, per-input FIFO depth in entries; SHALL be a power of two, at least 2.
REQ-002 Parameter SKEW_LIMIT, default 16, consecutive one-sided cycles before a skew error.
REQ-003 Port list (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in1_pixel_r/g/b  in  8 each  stream 1 pixel.
- in1_valid  in  1  stream 1 data present.
- in1_ready  out  1  stream 1 accepted.
- in2_pixel_r/g/b  in  8 each  stream 2 pixel.
- in2_valid  in  1  stream 2 data present.
- in2_ready  out  1  stream 2 accepted.
- out1_pixel_r/g/b  out  8 each  head of FIFO 1.
- out2_pixel_r/g/b  out  8 each  head of FIFO 2.
- out_valid  out  1  paired pixels present.
- out_ready  in  1  downstream consumes pair.
- skew_error  out  1  sticky skew flag.
- clear_error  in  1  clears flag and flushes both FIFOs.

Function
REQ-004 Pixel field order SHALL be r, g, b.
REQ-005 Each input stream SHALL write into its own FIFO on the cycle it has valid and ready both high.
REQ-006 inN_ready SHALL equal NOT full(FIFO N), decoded from registered state only; there is no bypass when full.
REQ-007 out_valid SHALL be high exactly when both FIFOs are non-empty.
REQ-008 A pair SHALL pop from both FIFOs together on the cycle out_valid and out_ready are both high; never one side alone.
REQ-009 outN_pixel SHALL show the FIFO N head combinationally from storage.
REQ-010 outN_pixel SHALL hold stable while out_valid is high and out_ready is low.
REQ-011 Latency from push in cycle N to earliest out_valid SHALL be cycle N+1.
REQ-012 Throughput SHALL be one pair per cycle when both inputs stream and out_ready is held high.
REQ-013 A push and a pop on the same FIFO in the same cycle SHALL leave its occupancy unchanged.
REQ-014 A non-full FIFO SHALL accept a push while its head pops.
REQ-015 Occupancy counters SHALL be clog2(DEPTH)+1 bits wide.
REQ-016 Read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-017 The skew FSM SHALL have states RUN, SKEW and FAULT.
REQ-018 The skew counter SHALL count cycles in which exactly one FIFO is non-empty, and reset to 0 otherwise.
REQ-019 The FSM SHALL go RUN->SKEW when the skew counter becomes nonzero.
REQ-020 The FSM SHALL go SKEW->RUN when both FIFOs are empty or both are non-empty.
REQ-021 The FSM SHALL go SKEW->FAULT when the counter reaches SKEW_LIMIT.
REQ-022 In FAULT, skew_error SHALL be 1, and streaming SHALL otherwise continue normally.
REQ-023 clear_error high SHALL, next cycle, empty both FIFOs, zero the skew counter, enter RUN and drive skew_error to 0.
REQ-024 clear_error SHALL take priority over a push or pop in the same cycle; that push is dropped.

Reset
REQ-025 While rst is high, the FIFOs SHALL be empty and pointers 0.
REQ-026 While rst is high, out_valid SHALL be 0 and in1_ready, in2_ready SHALL be 1.
REQ-027 While rst is high, skew_error SHALL be 0 and the FSM in RUN with counter 0.
REQ-028 FIFO storage SHALL not be reset; outN_pixel are don't-care while out_valid is 0.
REQ-029 Reset mid-stream SHALL discard all buffered data with no partial pair output.

Structure
REQ-030 Package pixel_pkg SHALL hold pixel_t (r, g, b each 8 bits) and the skew state enum.
REQ-031 Top-level ports SHALL remain flattened per color.
REQ-032 Sub-module pixel_fifo (parameter DEPTH, push/pop/full/empty/head) SHALL be instantiated twice.
REQ-033 The skew FSM SHALL live in the top level.

Verification
REQ-034 Lockstep: both streams push r=01..10 (hex) each cycle with out_ready=1 -> pairs appear 1 cycle later, matching and in order, out_valid continuous.
REQ-035 Offset: stream 1 sends 3 pixels, then stream 2 sends 3 pixels 2 cycles later -> 3 pairs emitted in order, skew_error stays 0.
REQ-036 Backpressure: out_ready=0 with both streams pushing -> in1_ready/in2_ready fall after 4 pushes, and head holds r=01 until out_ready returns.
REQ-037 Skew fault: push 1 pixel on stream 1 only -> skew_error rises after 16 cycles, and clear_error then empties FIFOs with out_valid=0 and skew_error=0 next cycle.
REQ-038 Wrap: 20 pairs through DEPTH=4 with random out_ready -> no loss or reorder across pointer wrap.
REQ-039 Reset mid-stream: assert rst with 2 entries buffered -> out_valid=0, both ready=1, and the following pair is the first post-reset data.
